// File: rtl/mac_vert_column_sched.sv
// mac_vert_column_sched
// ---------------------------------------------------------------------------
// Column sequencer for one bit-serial vertical MAC datapath. A job descriptor
// (bit-column mask + chain flag) is accepted over cmd_valid/cmd_ready. The
// set bit-columns are walked from MSB to LSB, one per cycle that the operand
// feed has data. A single flush bubble follows so the one-cycle psum pipeline
// drains into the accumulator. The result is then offered to the collector
// with result_valid/result_ready backpressure.
//
// Ports
//   clk, reset             clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    job handshake (ready only while idle)
//   cmd_col_mask           bit c set -> column c is processed
//   cmd_chain              1: seed from accum_prev, 0: seed from zero
//   op_valid               operand feed holds data for mac_col_idx
//   abort                  drop the current job
//   mac_en                 datapath enable
//   mac_load_accum         datapath load_accum (first update of a job)
//   mac_col_idx            column index / operand fetch address
//   mac_is_msb             column index is the top bit-column
//   mac_bubble             flush cycle: wrapper zeroes act/sum/mul inputs
//   accum_prev_zero        wrapper substitutes 0 for accum_prev
//   result_valid/ready     result handshake to the output collector
//   busy_cycles            saturating count of non-idle cycles
// ---------------------------------------------------------------------------
module mac_vert_column_sched #(
    parameter int NUM_COLS = 8,
    parameter int COL_W    = $clog2(NUM_COLS),
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [NUM_COLS-1:0] cmd_col_mask,
    input  logic                cmd_chain,
    input  logic                op_valid,
    input  logic                abort,
    output logic                mac_en,
    output logic                mac_load_accum,
    output logic [COL_W-1:0]    mac_col_idx,
    output logic                mac_is_msb,
    output logic                mac_bubble,
    output logic                accum_prev_zero,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [CNT_W-1:0]    busy_cycles
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [NUM_COLS-1:0] rem_mask_q;
    logic                chain_q;
    logic                first_q;    // next datapath update is the job's first
    logic                aborted_q;  // current DRAIN was entered through abort
    logic [CNT_W-1:0]    busy_q;

    logic [COL_W-1:0]    col_sel;
    logic [NUM_COLS-1:0] sel_onehot;
    logic [NUM_COLS-1:0] rem_after;

    // Highest set bit of the remaining mask. The ascending loop lets the
    // highest match overwrite the lower ones.
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, otherwise the tool infers a latch for the untaken paths.
    always_comb begin
        col_sel    = '0;
        sel_onehot = '0;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (rem_mask_q[c]) begin
                col_sel       = COL_W'(c);
                sel_onehot    = '0;
                sel_onehot[c] = 1'b1;
            end
        end
    end

    assign rem_after = rem_mask_q & ~sel_onehot;

    // Datapath controls are decoded from state plus the live op_valid/abort,
    // so a stall removes mac_en in the same cycle the feed runs dry.
    always_comb begin
        cmd_ready      = 1'b0;
        mac_en         = 1'b0;
        mac_load_accum = 1'b0;
        mac_col_idx    = '0;
        mac_is_msb     = 1'b0;
        mac_bubble     = 1'b0;
        result_valid   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
            end
            S_ISSUE: begin
                mac_col_idx    = col_sel;
                mac_is_msb     = (col_sel == COL_W'(NUM_COLS - 1));
                mac_en         = op_valid & ~abort;
                mac_load_accum = first_q & op_valid & ~abort;
            end
            S_DRAIN: begin
                mac_en         = 1'b1;
                mac_bubble     = 1'b1;
                mac_load_accum = first_q;
            end
            S_DONE: begin
                result_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign accum_prev_zero = mac_load_accum & ~chain_q;
    assign busy_cycles     = busy_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            rem_mask_q <= '0;
            chain_q    <= 1'b0;
            first_q    <= 1'b0;
            aborted_q  <= 1'b0;
            busy_q     <= '0;
        end else begin
            if (state_q != S_IDLE && busy_q != '1) begin
                busy_q <= busy_q + CNT_W'(1);
            end

            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        rem_mask_q <= cmd_col_mask;
                        chain_q    <= cmd_chain;
                        first_q    <= 1'b1;
                        aborted_q  <= 1'b0;
                        state_q    <= (cmd_col_mask != '0) ? S_ISSUE : S_DRAIN;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        rem_mask_q <= '0;
                        aborted_q  <= 1'b1;
                        state_q    <= S_DRAIN;
                    end else if (op_valid) begin
                        rem_mask_q <= rem_after;
                        first_q    <= 1'b0;
                        if (rem_after == '0) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    first_q   <= 1'b0;
                    aborted_q <= 1'b0;
                    state_q   <= aborted_q ? S_IDLE : S_DONE;
                end
                S_DONE: begin
                    if (abort || result_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_vert_column_sched.sv
// Directed testbench for mac_vert_column_sched. Inputs change 1 time unit
// after the rising edge; outputs are compared on the falling edge.
module tb_mac_vert_column_sched;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_col_mask;
    logic       cmd_chain;
    logic       op_valid;
    logic       abort;
    logic       mac_en;
    logic       mac_load_accum;
    logic [2:0] mac_col_idx;
    logic       mac_is_msb;
    logic       mac_bubble;
    logic       accum_prev_zero;
    logic       result_valid;
    logic       result_ready;
    logic [15:0] busy_cycles;

    // Second instance with a tiny counter to reach saturation quickly.
    logic       s_cmd_ready, s_en, s_ld, s_msb, s_bub, s_apz, s_rv;
    logic [2:0] s_col;
    logic [2:0] s_busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mac_vert_column_sched #(.NUM_COLS(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_col_mask(cmd_col_mask), .cmd_chain(cmd_chain),
        .op_valid(op_valid), .abort(abort),
        .mac_en(mac_en), .mac_load_accum(mac_load_accum),
        .mac_col_idx(mac_col_idx), .mac_is_msb(mac_is_msb),
        .mac_bubble(mac_bubble), .accum_prev_zero(accum_prev_zero),
        .result_valid(result_valid), .result_ready(result_ready),
        .busy_cycles(busy_cycles)
    );

    mac_vert_column_sched #(.NUM_COLS(8), .CNT_W(3)) u_sat (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_col_mask(cmd_col_mask), .cmd_chain(cmd_chain),
        .op_valid(op_valid), .abort(abort),
        .mac_en(s_en), .mac_load_accum(s_ld),
        .mac_col_idx(s_col), .mac_is_msb(s_msb),
        .mac_bubble(s_bub), .accum_prev_zero(s_apz),
        .result_valid(s_rv), .result_ready(result_ready),
        .busy_cycles(s_busy)
    );

    // {cmd_ready, en, load_accum, col_idx[2:0], is_msb, bubble, apz, result_valid}
    logic [9:0] obs;
    assign obs = {cmd_ready, mac_en, mac_load_accum, mac_col_idx,
                  mac_is_msb, mac_bubble, accum_prev_zero, result_valid};

    function automatic logic [9:0] ev(input logic cr, input logic en,
                                      input logic ld, input logic [2:0] col,
                                      input logic msb, input logic bub,
                                      input logic apz, input logic rv);
        return {cr, en, ld, col, msb, bub, apz, rv};
    endfunction

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Compare the outputs for the current cycle, then advance one cycle.
    task automatic cyc(input string tag, input logic [9:0] exp);
        @(negedge clk);
        check(tag, 16'(obs), 16'(exp));
        @(posedge clk);
        #1;
    endtask

    localparam logic [9:0] IDLE_V = 10'b1_0_0_000_0_0_0_0;
    localparam logic [9:0] DONE_V = 10'b0_0_0_000_0_0_0_1;
    localparam logic [9:0] DRN_V  = 10'b0_1_0_000_0_1_0_0;

    initial begin
        reset        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_col_mask = '0;
        cmd_chain    = 1'b0;
        op_valid     = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b0;

        // ---- reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_outs", 16'(obs), 16'(IDLE_V));
        check("rst_busy", busy_cycles, 16'd0);
        reset = 1'b1;
        cyc("rst_idle", IDLE_V);

        // ---- T1: mask 1000_0101, chain 0, no stalls
        cmd_valid = 1'b1; cmd_col_mask = 8'h85; cmd_chain = 1'b0; op_valid = 1'b1;
        cyc("t1_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t1_col7", ev(0, 1, 1, 3'd7, 1, 0, 1, 0));
        cyc("t1_col2", ev(0, 1, 0, 3'd2, 0, 0, 0, 0));
        cyc("t1_col0", ev(0, 1, 0, 3'd0, 0, 0, 0, 0));
        cyc("t1_drain", DRN_V);
        result_ready = 1'b1;
        cyc("t1_done", DONE_V);
        result_ready = 1'b0;
        check("t1_busy", busy_cycles, 16'd5);
        cyc("t1_idle", IDLE_V);

        // ---- T2: same job, two stall cycles while column 2 is pending
        cmd_valid = 1'b1;
        cyc("t2_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t2_col7", ev(0, 1, 1, 3'd7, 1, 0, 1, 0));
        op_valid = 1'b0;
        cyc("t2_stall0", ev(0, 0, 0, 3'd2, 0, 0, 0, 0));
        cyc("t2_stall1", ev(0, 0, 0, 3'd2, 0, 0, 0, 0));
        op_valid = 1'b1;
        cyc("t2_col2", ev(0, 1, 0, 3'd2, 0, 0, 0, 0));
        cyc("t2_col0", ev(0, 1, 0, 3'd0, 0, 0, 0, 0));
        cyc("t2_drain", DRN_V);
        result_ready = 1'b1;
        cyc("t2_done", DONE_V);
        result_ready = 1'b0;
        check("t2_busy", busy_cycles, 16'd12);

        // ---- T3: empty mask with chain: drain loads accum_prev directly
        cmd_valid = 1'b1; cmd_col_mask = 8'h00; cmd_chain = 1'b1;
        cyc("t3_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t3_drain", ev(0, 1, 1, 3'd0, 0, 1, 0, 0));
        result_ready = 1'b1;
        cyc("t3_done", DONE_V);
        result_ready = 1'b0;

        // ---- T4: abort on second ISSUE cycle of mask FF
        cmd_valid = 1'b1; cmd_col_mask = 8'hFF; cmd_chain = 1'b0;
        cyc("t4_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t4_col7", ev(0, 1, 1, 3'd7, 1, 0, 1, 0));
        abort = 1'b1;
        cyc("t4_abort", ev(0, 0, 0, 3'd6, 0, 0, 0, 0));
        abort = 1'b0;
        cyc("t4_drain", DRN_V);
        cyc("t4_idle", IDLE_V);
        // follow-up job mask 01 runs normally
        cmd_valid = 1'b1; cmd_col_mask = 8'h01;
        cyc("t4b_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t4b_col0", ev(0, 1, 1, 3'd0, 0, 0, 1, 0));
        abort = 1'b1;  // ignored in DRAIN
        cyc("t4b_drain", DRN_V);
        abort = 1'b0;
        result_ready = 1'b1;
        cyc("t4b_done", DONE_V);
        result_ready = 1'b0;

        // ---- T5: DONE backpressure with a pending command
        cmd_valid = 1'b1; cmd_col_mask = 8'h40; cmd_chain = 1'b1;
        cyc("t5_accept", IDLE_V);
        cmd_col_mask = 8'h03; cmd_chain = 1'b0;
        cyc("t5_col6", ev(0, 1, 1, 3'd6, 0, 0, 0, 0));
        cyc("t5_drain", DRN_V);
        for (int i = 0; i < 5; i++) cyc($sformatf("t5_hold%0d", i), DONE_V);
        result_ready = 1'b1;
        cyc("t5_release", DONE_V);
        result_ready = 1'b0;
        cyc("t5_accept2", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t5_col1", ev(0, 1, 1, 3'd1, 0, 0, 1, 0));
        cyc("t5_col0", ev(0, 1, 0, 3'd0, 0, 0, 0, 0));
        cyc("t5_drain2", DRN_V);
        // abort in DONE drops the result
        abort = 1'b1;
        cyc("t5_done_abort", DONE_V);
        abort = 1'b0;
        cyc("t5_idle", IDLE_V);

        // ---- T6: asynchronous reset in the middle of ISSUE
        cmd_valid = 1'b1; cmd_col_mask = 8'hFF;
        cyc("t6_accept", IDLE_V);
        cmd_valid = 1'b0;
        cyc("t6_col7", ev(0, 1, 1, 3'd7, 1, 0, 1, 0));
        #2 reset = 1'b0;
        #1;
        check("t6_async_outs", 16'(obs), 16'(IDLE_V));
        check("t6_async_busy", busy_cycles, 16'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        cyc("t6_release", IDLE_V);

        // ---- T7: full mask; main counter counts, small counter saturates
        cmd_valid = 1'b1;
        cyc("t7_accept", IDLE_V);
        cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc($sformatf("t7_col%0d", 7 - i),
                ev(0, 1, (i == 0), 3'(7 - i), (i == 0), 0, (i == 0), 0));
        end
        cyc("t7_drain", DRN_V);
        result_ready = 1'b1;
        cyc("t7_done", DONE_V);
        result_ready = 1'b0;
        check("t7_busy", busy_cycles, 16'd10);
        check("t7_busy_sat", 16'(s_busy), 16'd7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the bench always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mac_vert_column_sched.md
Name: mac_vert_column_sched

Overview:
Column sequencer for one mac_unit_Vert_16_small_mul instance. It accepts a job descriptor (bit-column mask and chain flag) over a valid/ready handshake. It walks the non-zero weight bit-columns from MSB to LSB, driving column_idx/is_msb/en/load_accum, and inserts the flush bubble that the one-cycle psum pipeline needs. It then presents result_valid to the output collector with backpressure.

Parameters:
NUM_COLS, 8, number of weight bit-columns (weight DATA_WIDTH)
COL_W, $clog2(NUM_COLS), width of column index
CNT_W, 16, width of busy-cycle performance counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  job descriptor valid
cmd_ready  out  1  scheduler can accept a job
cmd_col_mask  in  NUM_COLS  bit c=1 -> column c must be processed
cmd_chain  in  1  1: seed accumulator from accum_prev; 0: seed from zero
op_valid  in  1  operand feed (act_sel/act_val/sum_act/mul_const) ready for column on col_idx
abort  in  1  drop current job
mac_en  out  1  drives datapath en
mac_load_accum  out  1  drives load_accum
mac_col_idx  out  COL_W  drives column_idx; also operand-feed fetch address
mac_is_msb  out  1  drives is_msb
mac_bubble  out  1  wrapper forces act_val=0, sum_act=0, en_mul=0 this cycle
accum_prev_zero  out  1  wrapper muxes accum_prev to 0
result_valid  out  1  datapath result is final
result_ready  in  1  collector consumed result
busy_cycles  out  CNT_W  saturating count of cycles not in IDLE

Behaviour:
- Async reset (reset=0): state=IDLE, rem_mask=0, chain=0, busy_cycles=0. All outputs 0 except cmd_ready=1.
- States: IDLE, ISSUE, DRAIN, DONE. cmd_ready=1 only in IDLE.
- IDLE: on cmd_valid, latch mask into rem_mask and latch chain. first=1. Go to ISSUE if mask!=0, else DRAIN.
- ISSUE: mac_col_idx = highest set bit of rem_mask (combinational priority encode). mac_is_msb = (mac_col_idx==NUM_COLS-1).
  - op_valid=1: mac_en=1, mac_load_accum=first, clear that bit in rem_mask, first<=0. If it was the last set bit, go to DRAIN.
  - op_valid=0: mac_en=0, mac_load_accum=0. Hold col, rem_mask and first (stall; no datapath update).
- DRAIN (exactly 1 cycle): mac_en=1, mac_bubble=1, mac_load_accum=first. The datapath adds the delayed psum of the last column; the psum register refills with 0, so the next job starts clean. mac_col_idx=0, mac_is_msb=0. Next state is DONE, or IDLE if the drain was caused by abort.
- Empty mask: DRAIN with first=1, so result = accum_prev (chain) or 0.
- DONE: result_valid=1, held with the datapath frozen (mac_en=0) until result_ready. Then go to IDLE; cmd_ready rises the following cycle.
- accum_prev_zero = ~chain whenever mac_load_accum=1; otherwise 0.
- Latency: job with k set bits and no stalls, accepted at cycle t: ISSUE t+1..t+k, DRAIN t+k+1, result_valid at t+k+2. Each op_valid=0 cycle adds 1.
- abort:
  - In ISSUE: takes priority over op_valid. mac_en=0 that cycle, rem_mask cleared, go to DRAIN flagged aborted. The bubble flushes the psum register; then go to IDLE with no result_valid.
  - In IDLE or DRAIN: ignored.
  - In DONE: drops the result and goes to IDLE.
- Simultaneous result_ready and cmd_valid in DONE: cmd not accepted (cmd_ready=0); the job is accepted next cycle from IDLE.
- busy_cycles increments every non-IDLE cycle and saturates at all-ones.
- mac_* outputs are combinational from state/rem_mask/op_valid. No output glitches on stall beyond op_valid's own.

Test Plan:
- mask=8'b1000_0101, chain=0, op_valid=1 -> mac_col_idx 7,2,0 on cycles t+1..t+3. is_msb only at t+1, load_accum only at t+1, accum_prev_zero=1. DRAIN bubble at t+4, result_valid at t+5. Datapath result equals golden dot product.
- Same job, op_valid low for 2 cycles while col 2 pending -> col_idx holds 2, mac_en=0 both cycles, result_valid at t+7, result unchanged.
- mask=0, chain=1, accum_prev=24'h001234 -> DRAIN with load_accum=1 at t+1, result_valid at t+2, accum_out=24'h001234.
- abort asserted on second ISSUE cycle of mask=8'hFF -> DRAIN bubble next cycle, then IDLE, no result_valid. Next job mask=8'h01 produces the correct result (psum register is clean).
- result_ready held 0 for 5 cycles in DONE with cmd_valid=1 -> result_valid stays high, mac_en=0, cmd_ready=0. Job accepted the cycle after result_ready.
- reset pulsed low mid-ISSUE -> all outputs 0 immediately (async), cmd_ready=1 after release, busy_cycles=0.
